// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one memory-side bus master port between a CPU
// slave port and two read-only DMA requesters (video, sound).
//
// Ports
//   clkcpu, rst_i          clock (rising edge), asynchronous active-high reset
//   cpu_cyc/stb/we/sel/adr CPU bus cycle request; cpu_ack returned
//   vid_req/vid_adr        video quad-word request; vid_ack pulses per word
//   snd_req/snd_adr        sound quad-word request; snd_ack pulses per word
//   mem_*_o, mem_ack_i     registered memory master port
//   grant_o                current owner: 00 none, 01 CPU, 10 video, 11 sound
//
// Addresses are 32-bit word addresses carried as bits [23:2] (22 bits).
//
// Build option: define ARB_BURST_EN to issue each DMA quad as one
// incrementing burst (cti 010,010,010,111). Left undefined, a quad is four
// classic cycles with one idle strobe cycle (GAP) between beats.
module mem_arbiter (
  input  logic        clkcpu,
  input  logic        rst_i,
  input  logic        cpu_cyc,
  input  logic        cpu_stb,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_sel,
  input  logic [21:0] cpu_adr,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [21:0] vid_adr,
  output logic        vid_ack,
  input  logic        snd_req,
  input  logic [21:0] snd_adr,
  output logic        snd_ack,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [2:0]  mem_cti_o,
  output logic [21:0] mem_adr_o,
  input  logic        mem_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DMA  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_CPU  = 2'b01;
  localparam logic [1:0] G_VID  = 2'b10;
  localparam logic [1:0] G_SND  = 2'b11;

  localparam logic [2:0] CTI_CLASSIC  = 3'b000;
`ifdef ARB_BURST_EN
  localparam logic [2:0] CTI_INCR     = 3'b010;
  localparam logic [2:0] CTI_EOB      = 3'b111;
`endif
  localparam logic [2:0] STARVE_LIMIT = 3'd4;

  state_t      state, state_nxt;
  logic [1:0]  grant_nxt;
  logic [1:0]  beat, beat_nxt;
  logic [2:0]  starve, starve_nxt;
  logic [19:0] quad_base, quad_base_nxt;

  logic        cyc_nxt, stb_nxt, we_nxt;
  logic [3:0]  sel_nxt;
  logic [2:0]  cti_nxt;
  logic [21:0] adr_nxt;

  logic        cpu_req;
  logic        dma_adr_unused;

  assign cpu_req = cpu_cyc & cpu_stb;

  // DMA quads are always aligned, so the low word-select bits of the
  // requester addresses are intentionally dropped.
  assign dma_adr_unused = ^{vid_adr[1:0], snd_adr[1:0]};

  // Acks are combinational so the requester sees them in the same cycle
  // as the memory ack. CPU ack is suppressed once the CPU has abandoned
  // its cycle; DMA acks go only to the requester that owns the quad.
  assign cpu_ack = (state == S_CPU) & cpu_cyc & mem_ack_i;
  assign vid_ack = (state == S_DMA) & (grant_o == G_VID) & mem_ack_i;
  assign snd_ack = (state == S_DMA) & (grant_o == G_SND) & mem_ack_i;

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_o;
    beat_nxt      = beat;
    starve_nxt    = starve;
    quad_base_nxt = quad_base;
    cyc_nxt       = mem_cyc_o;
    stb_nxt       = mem_stb_o;
    we_nxt        = mem_we_o;
    sel_nxt       = mem_sel_o;
    cti_nxt       = mem_cti_o;
    adr_nxt       = mem_adr_o;

    case (state)
      S_IDLE: begin
        if (!cpu_req) begin
          starve_nxt = 3'd0;
        end
        // A starved CPU wins over any DMA request; otherwise sound beats
        // video beats CPU.
        if (cpu_req && ((starve >= STARVE_LIMIT) || (!snd_req && !vid_req))) begin
          state_nxt  = S_CPU;
          grant_nxt  = G_CPU;
          starve_nxt = 3'd0;
          cyc_nxt    = 1'b1;
          stb_nxt    = 1'b1;
          we_nxt     = cpu_we;
          sel_nxt    = cpu_sel;
          cti_nxt    = CTI_CLASSIC;
          adr_nxt    = cpu_adr;
        end else if (snd_req || vid_req) begin
          state_nxt     = S_DMA;
          grant_nxt     = snd_req ? G_SND : G_VID;
          quad_base_nxt = snd_req ? snd_adr[21:2] : vid_adr[21:2];
          beat_nxt      = 2'd0;
          cyc_nxt       = 1'b1;
          stb_nxt       = 1'b1;
          we_nxt        = 1'b0;
          sel_nxt       = 4'hF;
`ifdef ARB_BURST_EN
          cti_nxt       = CTI_INCR;
`else
          cti_nxt       = CTI_CLASSIC;
`endif
          adr_nxt       = {quad_base_nxt, 2'b00};
        end
      end

      S_CPU: begin
        we_nxt  = cpu_we;
        sel_nxt = cpu_sel;
        adr_nxt = cpu_adr;
        // Completion and abort both end the cycle; an abort never acks.
        if (!cpu_cyc || mem_ack_i) begin
          state_nxt = S_IDLE;
          grant_nxt = G_NONE;
          cyc_nxt   = 1'b0;
          stb_nxt   = 1'b0;
        end
      end

      S_DMA: begin
        if (mem_ack_i) begin
          if (beat == 2'd3) begin
            state_nxt = S_IDLE;
            grant_nxt = G_NONE;
            beat_nxt  = 2'd0;
            cyc_nxt   = 1'b0;
            stb_nxt   = 1'b0;
            cti_nxt   = CTI_CLASSIC;
            if (cpu_req && (starve < STARVE_LIMIT)) begin
              starve_nxt = starve + 3'd1;
            end
          end else begin
            // Beat counter only ever replaces [3:2]; the quad base is fixed.
            beat_nxt = beat + 2'd1;
            adr_nxt  = {quad_base, beat_nxt};
`ifdef ARB_BURST_EN
            cti_nxt  = (beat_nxt == 2'd3) ? CTI_EOB : CTI_INCR;
`else
            state_nxt = S_GAP;
            stb_nxt   = 1'b0;
`endif
          end
        end
      end

      S_GAP: begin
        state_nxt = S_DMA;
        stb_nxt   = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
        grant_nxt = G_NONE;
        cyc_nxt   = 1'b0;
        stb_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkcpu or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      grant_o   <= G_NONE;
      beat      <= 2'd0;
      starve    <= 3'd0;
      quad_base <= 20'd0;
      mem_cyc_o <= 1'b0;
      mem_stb_o <= 1'b0;
      mem_we_o  <= 1'b0;
      mem_sel_o <= 4'h0;
      mem_cti_o <= CTI_CLASSIC;
      mem_adr_o <= 22'd0;
    end else begin
      state     <= state_nxt;
      grant_o   <= grant_nxt;
      beat      <= beat_nxt;
      starve    <= starve_nxt;
      quad_base <= quad_base_nxt;
      mem_cyc_o <= cyc_nxt;
      mem_stb_o <= stb_nxt;
      mem_we_o  <= we_nxt;
      mem_sel_o <= sel_nxt;
      mem_cti_o <= cti_nxt;
      mem_adr_o <= adr_nxt;
    end
  end

endmodule
